// File: rtl/icap_ctrl_if.sv
// Handshake bundle between the ICAP controller and its surroundings.
//   host_valid/host_data/host_ready : host word stream (valid/ready)
//   reboot/boot_addr                : single-cycle multiboot request plus address
//   busy                            : controller occupied
//   icap_w/icap_i                   : write strobe and word to the ICAP port
// master drives host words and reboot requests; slave is the controller.
interface icap_ctrl_if;
  logic        host_valid;
  logic [15:0] host_data;
  logic        host_ready;
  logic        reboot;
  logic [23:0] boot_addr;
  logic        busy;
  logic        icap_w;
  logic [15:0] icap_i;

  modport master (
    output host_valid, host_data, reboot, boot_addr,
    input  host_ready, busy, icap_w, icap_i
  );

  modport slave (
    input  host_valid, host_data, reboot, boot_addr,
    output host_ready, busy, icap_w, icap_i
  );
endinterface

// File: rtl/icap_ctrl.sv
// ICAP write-port sequencer/arbiter. Shares the 16-bit ICAP write port between a host
// word stream and a multiboot reboot engine that emits the IPROG sequence, keeping at
// least GAP cycles between consecutive write strobes.
// Ports:
//   c     : clock
//   rst_n : asynchronous active-low reset
//   bus   : icap_ctrl_if.slave (host stream, reboot request, busy, ICAP strobe/word)
module icap_ctrl #(
  parameter int unsigned GAP         = 16,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000
) (
  input logic        c,
  input logic        rst_n,
  icap_ctrl_if.slave bus
);

  if (GAP < 16) begin : g_gap_chk
    $error("icap_ctrl: GAP must be >= 16");
  end

  localparam int unsigned CW       = $clog2(GAP);
  localparam logic [CW-1:0] CntHost = CW'(GAP - 1);
  localparam logic [CW-1:0] CntSeq  = CW'(GAP - 2);
  localparam logic [3:0]    LastIdx = 4'd13;

  typedef enum logic [2:0] {StIdle, StWait, StSeq, StSeqWait, StHalt} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [23:0]   addr_q, addr_d;
  logic          w_q, w_d;
  logic [15:0]   i_q, i_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          acc_host, acc_reboot, pend_eff;
  logic [15:0]   seq_word;

  // Reboot gates ready combinationally so it wins a same-cycle tie with the host.
  assign bus.host_ready = ready_q & ~bus.reboot;
  assign bus.busy       = busy_q;
  assign bus.icap_w     = w_q;
  assign bus.icap_i     = i_q;

  assign acc_host   = bus.host_valid & bus.host_ready;
  // Once a sequence is pending or running, further requests are ignored.
  assign acc_reboot = bus.reboot & ~pend_q & ((state_q == StIdle) | (state_q == StWait));
  assign pend_eff   = pend_q | acc_reboot;

  always_comb begin
    case (idx_q)
      4'd0:    seq_word = 16'hFFFF;
      4'd1:    seq_word = 16'hAA99;
      4'd2:    seq_word = 16'h5566;
      4'd3:    seq_word = 16'h3261;
      4'd4:    seq_word = addr_q[15:0];
      4'd5:    seq_word = 16'h3281;
      4'd6:    seq_word = {8'h03, addr_q[23:16]};
      4'd7:    seq_word = 16'h32A1;
      4'd8:    seq_word = GOLDEN_ADDR[15:0];
      4'd9:    seq_word = 16'h32C1;
      4'd10:   seq_word = {8'h03, GOLDEN_ADDR[23:16]};
      4'd11:   seq_word = 16'h30A1;
      4'd12:   seq_word = 16'h000E;
      default: seq_word = 16'h2000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_eff;
    addr_d  = acc_reboot ? bus.boot_addr : addr_q;
    w_d     = 1'b0;
    i_d     = i_q;

    case (state_q)
      StIdle: begin
        if (pend_eff) begin
          state_d = StSeq;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (acc_host) begin
          state_d = StWait;
          cnt_d   = CntHost;
          w_d     = 1'b1;
          i_d     = bus.host_data;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        // Enter SEQ one cycle early so the first sequence strobe lands exactly GAP
        // cycles after the host strobe, matching the in-sequence spacing.
        if (pend_eff && (cnt_q <= CW'(1))) begin
          state_d = StSeq;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end
      end
      StSeq: begin
        w_d = 1'b1;
        i_d = seq_word;
        if (idx_q == LastIdx) begin
          state_d = StHalt;
        end else begin
          state_d = StSeqWait;
          cnt_d   = CntSeq;
          idx_d   = idx_q + 4'd1;
        end
      end
      StSeqWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StSeq;
      end
      default: state_d = StHalt;
    endcase

    ready_d = (state_d == StIdle) & ~pend_d;
    busy_d  = (state_d != StIdle) | pend_d;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      w_q     <= 1'b0;
      i_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      i_q     <= i_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_icap_ctrl.sv
module tb_icap_ctrl;

  localparam int          Gap    = 16;
  localparam logic [23:0] Golden = 24'h000000;

  logic c = 1'b0;
  logic rst_n = 1'b1;
  always #5 c = ~c;

  icap_ctrl_if bus ();

  icap_ctrl #(
    .GAP         (Gap),
    .GOLDEN_ADDR (Golden)
  ) dut (
    .c     (c),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] w;
    int          at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_strobe = 0;

  // Reference model state
  int   idle_from;      // first cycle the host may be accepted
  int   busy_until;     // busy while cyc < busy_until after a host write
  int   last_s;         // cycle of the last host strobe
  bit   seq_active;
  int   seq_busy_from;

  always @(posedge c) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor: every strobe must match the head of the expectation queue.
  always @(negedge c) begin
    if (rst_n && bus.icap_w) begin
      n_strobe++;
      if (q.size() == 0) begin
        check("unexpected_strobe", {16'h0, bus.icap_i}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_word", {16'h0, bus.icap_i}, {16'h0, e.w});
        check("strobe_cycle", cyc, e.at);
      end
    end
  end

  task automatic push_sequence(input logic [23:0] a, input int first);
    logic [15:0] w[14];
    w = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281, {8'h03, a[23:16]},
          16'h32A1, Golden[15:0], 16'h32C1, {8'h03, Golden[23:16]}, 16'h30A1, 16'h000E,
          16'h2000};
    for (int k = 0; k < 14; k++) q.push_back('{w: w[k], at: first + k * Gap});
  endtask

  // One cycle of stimulus plus per-cycle ready/busy comparison against the model.
  task automatic step(input logic hv, input logic [15:0] hd, input logic rb,
                      input logic [23:0] ba, output logic acc);
    bit mready, mbusy;
    @(negedge c);
    bus.host_valid = hv;
    bus.host_data  = hd;
    bus.reboot     = rb;
    bus.boot_addr  = ba;
    #1;
    mready = !seq_active && (cyc >= idle_from) && !rb;
    mbusy  = (seq_active && (cyc >= seq_busy_from)) || (cyc < busy_until);
    check("host_ready", {31'h0, bus.host_ready}, {31'h0, mready});
    check("busy", {31'h0, bus.busy}, {31'h0, mbusy});
    acc = hv && mready;
    if (acc) begin
      last_s     = cyc + 1;
      busy_until = last_s + Gap;
      idle_from  = last_s + Gap;
      q.push_back('{w: hd, at: last_s});
    end
    if (rb && !seq_active) begin
      seq_active    = 1'b1;
      seq_busy_from = cyc + 1;
      push_sequence(ba, (cyc + 2 > last_s + Gap) ? cyc + 2 : last_s + Gap);
    end
  endtask

  task automatic do_reset();
    @(posedge c);
    #2;
    rst_n          = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.reboot     = 1'b0;
    bus.boot_addr  = '0;
    #1;
    check("rst_icap_w", {31'h0, bus.icap_w}, 32'h0);
    check("rst_icap_i", {16'h0, bus.icap_i}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_host_ready", {31'h0, bus.host_ready}, 32'h0);
    repeat (2) @(negedge c);
    rst_n = 1'b1;
    q.delete();
    idle_from     = cyc + 1;
    busy_until    = 0;
    last_s        = -1000;
    seq_active    = 1'b0;
    seq_busy_from = 0;
  endtask

  task automatic host_write(input logic [15:0] d);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) step(1'b1, d, 1'b0, 24'h0, acc);
    check("host_accept", {31'h0, acc}, 32'h1);
  endtask

  // Idle until all expected strobes are seen; optionally keep host_valid up, pulse a
  // late reboot after rb_at strobes, or stop early after stop_at strobes.
  task automatic drain(input int bound, input logic hv, input logic [15:0] hd,
                       input int rb_at, input logic [23:0] rb_addr, input int stop_at);
    logic acc;
    int   base;
    bit   rb_done;
    base    = n_strobe;
    rb_done = 1'b0;
    for (int i = 0; i < bound && q.size() != 0; i++) begin
      if (stop_at > 0 && n_strobe - base >= stop_at) return;
      if (rb_at > 0 && !rb_done && n_strobe - base >= rb_at) begin
        rb_done = 1'b1;
        step(hv, hd, 1'b1, rb_addr, acc);
      end else begin
        step(hv, hd, 1'b0, 24'h0, acc);
      end
    end
    check("drain_empty", q.size(), 32'h0);
  endtask

  initial begin
    logic        acc;
    logic        pending;
    logic [15:0] d;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.reboot     = 1'b0;
    bus.boot_addr  = '0;

    // Basic host writes and spacing
    do_reset();
    host_write(16'h1234);
    host_write(16'h5678);

    // Random host traffic
    pending = 1'b0;
    d       = '0;
    for (int i = 0; i < 120; i++) begin
      if (!pending) begin
        pending = ($urandom_range(0, 2) == 0);
        d       = 16'($urandom);
      end
      step(pending, d, 1'b0, 24'h0, acc);
      if (acc) pending = 1'b0;
    end
    step(1'b0, 16'h0, 1'b0, 24'h0, acc);
    drain(40, 1'b0, 16'h0, 0, 24'h0, 0);

    // Reboot from IDLE, full sequence, then HALT
    repeat (20) step(1'b0, 16'h0, 1'b0, 24'h0, acc);
    step(1'b0, 16'h0, 1'b1, 24'h0A_BCDE, acc);
    drain(14 * Gap + 40, 1'b0, 16'h0, 0, 24'h0, 0);
    repeat (500) step(1'b0, 16'h0, 1'b0, 24'h0, acc);

    // Host write, reboot 3 cycles later, host held off, late reboot ignored
    do_reset();
    host_write(16'($urandom));
    d = 16'($urandom);
    step(1'b1, d, 1'b0, 24'h0, acc);
    step(1'b1, d, 1'b0, 24'h0, acc);
    step(1'b1, d, 1'b1, 24'h0A_BCDE, acc);
    drain(14 * Gap + 40, 1'b1, d, 5, 24'h12_3456, 0);
    repeat (30) step(1'b1, d, 1'b0, 24'h0, acc);

    // Same-cycle reboot and host word; reset mid-sequence
    do_reset();
    step(1'b0, 16'h0, 1'b0, 24'h0, acc);
    d = 16'($urandom);
    step(1'b1, d, 1'b1, 24'($urandom), acc);
    drain(14 * Gap + 40, 1'b1, d, 0, 24'h0, 7);
    do_reset();
    for (int i = 0; i < 5; i++) host_write(16'($urandom));
    step(1'b0, 16'h0, 1'b0, 24'h0, acc);
    drain(40, 1'b0, 16'h0, 0, 24'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
